packetizer_rr_arbiter: RTL and testbench

- Shares one packetizer_3_sub-style packetizer among NUM_PORTS independent client streams.
- Each client presents data, destination router address and VC with a valid/ready handshake.
- The block selects one client per cycle by round-robin and registers its fields into a single-entry output stage.
- That output stage drives the packetizer's data_in/dst_in/vc_in/valid_in and honours its ready_out.

---
 rtl/packetizer_rr_arbiter.sv | 101 ++++++++++
 tb/tb_packetizer_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS client streams into one registered output
// stage feeding a shared packetizer.
module packetizer_rr_arbiter #(
    parameter  int unsigned NUM_PORTS        = 4,
    parameter  int unsigned WIDTH_IN         = 12,
    parameter  int unsigned ADDRESS_WIDTH    = 4,
    parameter  int unsigned VC_ADDRESS_WIDTH = 1,
    localparam int unsigned SRC_WIDTH        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS*WIDTH_IN-1:0]          data_in,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]     dst_in,
    input  logic [NUM_PORTS*VC_ADDRESS_WIDTH-1:0]  vc_in,
    input  logic [NUM_PORTS-1:0]                   valid_in,
    output logic [NUM_PORTS-1:0]                   ready_out,
    output logic [WIDTH_IN-1:0]                    data_out,
    output logic [ADDRESS_WIDTH-1:0]               dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]            vc_out,
    output logic [SRC_WIDTH-1:0]                   src_out,
    output logic                                   valid_out,
    input  logic                                   ready_in
);

    logic                        full_q;
    logic [SRC_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WIDTH_IN-1:0]         data_q;
    logic [ADDRESS_WIDTH-1:0]    dst_q;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q;
    logic [SRC_WIDTH-1:0]        src_q;

    logic                        found;
    logic [SRC_WIDTH-1:0]        win_idx;
    logic [WIDTH_IN-1:0]         win_data;
    logic [ADDRESS_WIDTH-1:0]    win_dst;
    logic [VC_ADDRESS_WIDTH-1:0] win_vc;
    logic                        load;
    logic                        grant;

    // Scan from rr_ptr upward with wrap; first requester wins and its fields are muxed out.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_data = '0;
        win_dst  = '0;
        win_vc   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
            if (!found && valid_in[idx]) begin
                found    = 1'b1;
                win_idx  = SRC_WIDTH'(idx);
                win_data = data_in[idx*WIDTH_IN +: WIDTH_IN];
                win_dst  = dst_in[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                win_vc   = vc_in[idx*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
            end
        end
    end

    always_comb begin
        load  = !full_q || ready_in;
        grant = load && found;
        if (32'(win_idx) == NUM_PORTS - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_idx + 1'b1;
        end
        ready_out = '0;
        if (grant && !rst) begin
            ready_out[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 1'b0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            dst_q    <= '0;
            vc_q     <= '0;
            src_q    <= '0;
        end else if (grant) begin
            full_q   <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= win_data;
            dst_q    <= win_dst;
            vc_q     <= win_vc;
            src_q    <= win_idx;
        end else if (ready_in) begin
            // Drained with nothing to replace it; fields keep their last value.
            full_q <= 1'b0;
        end
    end

    assign valid_out = full_q;
    assign data_out  = data_q;
    assign dst_out   = dst_q;
    assign vc_out    = vc_q;
    assign src_out   = src_q;

endmodule

// File: tb/tb_packetizer_rr_arbiter.sv
// Directed bench for packetizer_rr_arbiter: per-cycle compare against a queue-free
// behavioural model plus hand-computed literal expectations.
module tb_packetizer_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int AW = 4;
    localparam int VW = 1;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*W-1:0]    data_in = '0;
    logic [N*AW-1:0]   dst_in = '0;
    logic [N*VW-1:0]   vc_in = '0;
    logic [N-1:0]      valid_in = '0;
    logic [N-1:0]      ready_out;
    logic [W-1:0]      data_out;
    logic [AW-1:0]     dst_out;
    logic [VW-1:0]     vc_out;
    logic [SW-1:0]     src_out;
    logic              valid_out;
    logic              ready_in = 1'b1;

    int checks = 0;
    int failures = 0;

    packetizer_rr_arbiter #(
        .NUM_PORTS(N), .WIDTH_IN(W), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dst_in(dst_in), .vc_in(vc_in),
        .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out), .dst_out(dst_out),
        .vc_out(vc_out), .src_out(src_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a "slot" holding one word plus a pointer to the next favoured client.
    int          m_ptr;
    bit          m_full;
    logic [W-1:0]  m_data;
    logic [AW-1:0] m_dst;
    logic [VW-1:0] m_vc;
    int          m_src;
    int          m_win;

    function automatic int first_from(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always_comb m_win = first_from(m_ptr, valid_in);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= 0; m_full <= 0; m_data <= '0; m_dst <= '0; m_vc <= '0; m_src <= 0;
        end else if ((!m_full || ready_in) && m_win >= 0) begin
            m_full <= 1;
            m_ptr  <= (m_win + 1) % N;
            m_data <= data_in[m_win*W +: W];
            m_dst  <= dst_in[m_win*AW +: AW];
            m_vc   <= vc_in[m_win*VW +: VW];
            m_src  <= m_win;
        end else if (ready_in) begin
            m_full <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] exp_rdy;
            exp_rdy = '0;
            if (m_win >= 0 && (!m_full || ready_in)) exp_rdy[m_win] = 1'b1;
            chk("model_ready_out", 32'(ready_out), 32'(exp_rdy));
            chk("model_valid_out", 32'(valid_out), 32'(m_full));
            chk("model_data_out", 32'(data_out), 32'(m_data));
            chk("model_dst_out", 32'(dst_out), 32'(m_dst));
            chk("model_vc_out", 32'(vc_out), 32'(m_vc));
            chk("model_src_out", 32'(src_out), 32'(m_src));
        end
    end

    task automatic set_client(input int i, input bit v, input logic [W-1:0] d,
                              input logic [AW-1:0] a, input logic [VW-1:0] c);
        valid_in[i]       = v;
        data_in[i*W +: W] = d;
        dst_in[i*AW +: AW] = a;
        vc_in[i*VW +: VW] = c;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_ready_out", 32'(ready_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        edge1();
        edge1();
        rst = 1'b0;

        // 1: all four valid, ready_in high -> 0,1,2,3,0,1
        for (int i = 0; i < N; i++) set_client(i, 1'b1, 12'hA00 + 12'(i), 4'(i), 1'(i));
        #1;
        chk("t1_first_ready", 32'(ready_out), 32'h1);
        for (int k = 0; k < 6; k++) begin
            edge1();
            chk("t1_data", 32'(data_out), 32'hA00 + 32'(k % 4));
            chk("t1_src", 32'(src_out), 32'(k % 4));
            chk("t1_valid", 32'(valid_out), 1);
            chk("t1_ready", 32'(ready_out), 32'(1 << ((k + 1) % 4)));
        end

        // 2: only client 2 valid
        for (int i = 0; i < N; i++) set_client(i, 1'b0, '0, '0, '0);
        set_client(2, 1'b1, 12'h3C3, 4'h5, 1'b1);
        #1;
        chk("t2_ready", 32'(ready_out), 32'b0100);
        edge1();
        chk("t2_data", 32'(data_out), 32'h3C3);
        chk("t2_dst", 32'(dst_out), 32'h5);
        chk("t2_vc", 32'(vc_out), 1);
        chk("t2_src", 32'(src_out), 2);
        chk("t2_valid", 32'(valid_out), 1);

        // 3: backpressure for three cycles, then drain and reload with no bubble
        set_client(2, 1'b0, '0, '0, '0);
        set_client(0, 1'b1, 12'h100, 4'h1, 1'b0);
        set_client(1, 1'b1, 12'h101, 4'h2, 1'b1);
        ready_in = 1'b0;
        #1;
        chk("t3_ready_stall", 32'(ready_out), 0);
        for (int k = 0; k < 3; k++) begin
            edge1();
            chk("t3_hold_data", 32'(data_out), 32'h3C3);
            chk("t3_hold_valid", 32'(valid_out), 1);
            chk("t3_hold_ready", 32'(ready_out), 0);
        end
        ready_in = 1'b1;
        #1;
        chk("t3_release_ready", 32'(ready_out), 32'b0001);
        edge1();
        chk("t3_reload_data", 32'(data_out), 32'h100);
        chk("t3_reload_src", 32'(src_out), 0);
        chk("t3_reload_valid", 32'(valid_out), 1);

        // 4: steer rr_ptr to 3 via client 2, then 0 and 3 compete
        set_client(0, 1'b0, '0, '0, '0);
        set_client(1, 1'b0, '0, '0, '0);
        set_client(2, 1'b1, 12'h222, 4'h2, 1'b0);
        edge1();
        chk("t4_prep_src", 32'(src_out), 2);
        set_client(2, 1'b0, '0, '0, '0);
        set_client(0, 1'b1, 12'h300, 4'h0, 1'b1);
        set_client(3, 1'b1, 12'h333, 4'h3, 1'b1);
        #1;
        chk("t4_ready_wrap", 32'(ready_out), 32'b1000);
        edge1();
        chk("t4_data3", 32'(data_out), 32'h333);
        chk("t4_src3", 32'(src_out), 3);
        chk("t4_ready0", 32'(ready_out), 32'b0001);
        edge1();
        chk("t4_data0", 32'(data_out), 32'h300);
        chk("t4_src0", 32'(src_out), 0);

        // 6: no clients valid while full and ready_in high -> drains, pointer stays at 1
        set_client(0, 1'b0, '0, '0, '0);
        set_client(3, 1'b0, '0, '0, '0);
        edge1();
        chk("t6_valid_drop", 32'(valid_out), 0);
        chk("t6_data_kept", 32'(data_out), 32'h300);
        set_client(1, 1'b1, 12'h011, 4'h1, 1'b0);
        set_client(3, 1'b1, 12'h033, 4'h3, 1'b0);
        #1;
        chk("t6_ptr_kept", 32'(ready_out), 32'b0010);

        // 5: asynchronous reset mid-stream
        edge1();
        chk("t5_pre_valid", 32'(valid_out), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(valid_out), 0);
        chk("t5_async_ready", 32'(ready_out), 0);
        chk("t5_async_data", 32'(data_out), 0);
        set_client(1, 1'b0, '0, '0, '0);
        set_client(2, 1'b1, 12'h0F2, 4'h7, 1'b1);
        edge1();
        rst = 1'b0;
        #1;
        chk("t5_first_grant", 32'(ready_out), 32'b0100);
        edge1();
        chk("t5_src", 32'(src_out), 2);
        chk("t5_data", 32'(data_out), 32'h0F2);

        for (int i = 0; i < N; i++) set_client(i, 1'b0, '0, '0, '0);
        edge1();
        edge1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
